// File: rtl/spi_mm_pkg.sv
// Shared constants for the SPI-to-MM bridge: bus widths, command bytes, frame length
// and FSM state encoding.
package spi_mm_pkg;

    localparam int unsigned MM_ADDR_WIDTH = 8;
    localparam int unsigned MM_DATA_WIDTH = 16;
    localparam int unsigned FRAME_BITS    = 32;

    localparam logic [7:0] CMD_WRITE = 8'h00;
    localparam logic [7:0] CMD_READ  = 8'h80;

    // Bit-counter values (bits already received) at which each field completes.
    localparam logic [4:0] CMD_LAST  = 5'd7;
    localparam logic [4:0] ADDR_LAST = 5'd15;
    localparam logic [4:0] DATA_LAST = 5'(FRAME_BITS - 1);

    typedef logic [2:0] state_t;
    localparam state_t StIdle   = 3'd0;
    localparam state_t StCmd    = 3'd1;
    localparam state_t StAddr   = 3'd2;
    localparam state_t StData   = 3'd3;
    localparam state_t StIgnore = 3'd4;

    function automatic logic is_valid_cmd(input logic [7:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/spi_mm_master_if.sv
// Internal memory-mapped bus: single master, combinational read data.
interface spi_mm_master_if;
    import spi_mm_pkg::*;

    logic [MM_ADDR_WIDTH-1:0] addr;
    logic [MM_DATA_WIDTH-1:0] wdata;
    logic [MM_DATA_WIDTH-1:0] rdata;
    logic                     we;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);

endinterface

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous bit with rise/fall detection.
module spi_sync #(
    parameter bit ResetVal = 1'b0
) (
    input  logic clk_sys_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= {2{ResetVal}};
            prev_q <= ResetVal;
        end else begin
            sync_q <= {sync_q[0], d_i};
            prev_q <= sync_q[1];
        end
    end

    assign q_o    = sync_q[1];
    assign rise_o = sync_q[1] & ~prev_q;
    assign fall_o = ~sync_q[1] & prev_q;

endmodule

// File: rtl/spi_mm_master.sv
// SPI mode-0 target that turns 32-bit frames (cmd, addr, data16) into single MM bus
// writes or reads, shifting read data back on MISO.
module spi_mm_master
    import spi_mm_pkg::*;
(
    input  logic            clk_sys_i,
    input  logic            rst_n_i,
    input  logic            spi_sck_i,
    input  logic            spi_cs_n_i,
    input  logic            spi_mosi_i,
    output logic            spi_miso_o,
    output logic            spi_miso_oe_o,
    spi_mm_master_if.master mm_m,
    output logic            frame_err_o
);

    logic sck_s, sck_rise, sck_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync #(.ResetVal(1'b0)) u_sync_sck (
        .clk_sys_i (clk_sys_i),
        .rst_n_i   (rst_n_i),
        .d_i       (spi_sck_i),
        .q_o       (sck_s),
        .rise_o    (sck_rise),
        .fall_o    (sck_fall)
    );

    // Resets as "asserted" so a CS_N already low when reset lifts never looks like a fall.
    spi_sync #(.ResetVal(1'b0)) u_sync_cs (
        .clk_sys_i (clk_sys_i),
        .rst_n_i   (rst_n_i),
        .d_i       (spi_cs_n_i),
        .q_o       (cs_n_s),
        .rise_o    (cs_rise),
        .fall_o    (cs_fall)
    );

    spi_sync #(.ResetVal(1'b0)) u_sync_mosi (
        .clk_sys_i (clk_sys_i),
        .rst_n_i   (rst_n_i),
        .d_i       (spi_mosi_i),
        .q_o       (mosi_s),
        .rise_o    (mosi_rise),
        .fall_o    (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_s, mosi_rise, mosi_fall};

    state_t                   state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [15:0]              rx_q, rx_d;
    logic [15:0]              tx_q, tx_d;
    logic                     is_read_q, is_read_d;
    logic [MM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                     we_pend_q, we_pend_d;
    logic                     we_q, we_d;
    logic                     rd_cap_q, rd_cap_d;
    logic                     miso_q, miso_d;
    logic                     oe_q, oe_d;
    logic                     err_q, err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        miso_d    = miso_q;
        we_pend_d = 1'b0;
        we_d      = we_pend_q;
        rd_cap_d  = 1'b0;
        err_d     = 1'b0;

        // Slave data is sampled the cycle after the address is driven.
        if (rd_cap_q) begin
            tx_d = mm_m.rdata;
        end

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StCmd;
                    cnt_d   = 5'd0;
                    rx_d    = 16'h0000;
                end
            end
            StCmd, StAddr, StData: begin
                if (sck_rise) begin
                    rx_d  = {rx_q[14:0], mosi_s};
                    cnt_d = (cnt_q == DATA_LAST) ? cnt_q : cnt_q + 5'd1;
                    if (state_q == StCmd && cnt_q == CMD_LAST) begin
                        if (is_valid_cmd(rx_d[7:0])) begin
                            state_d   = StAddr;
                            is_read_d = (rx_d[7:0] == CMD_READ);
                        end else begin
                            state_d = StIgnore;
                            err_d   = 1'b1;
                        end
                    end else if (state_q == StAddr && cnt_q == ADDR_LAST) begin
                        state_d  = StData;
                        addr_d   = rx_d[MM_ADDR_WIDTH-1:0];
                        rd_cap_d = is_read_q;
                    end else if (state_q == StData && cnt_q == DATA_LAST) begin
                        state_d = StIgnore;
                        miso_d  = 1'b0;
                        if (!is_read_q) begin
                            wdata_d   = rx_d;
                            we_pend_d = 1'b1;
                        end
                    end
                end else if (sck_fall && state_q == StData && is_read_q) begin
                    miso_d = tx_q[15];
                    tx_d   = {tx_q[14:0], 1'b0};
                end
            end
            StIgnore: ;
            default: state_d = StIdle;
        endcase

        // CS_N release always ends the frame; only an unfinished legal frame is an error.
        if (cs_rise) begin
            if (state_q == StCmd || state_q == StAddr || state_q == StData) begin
                err_d     = 1'b1;
                we_pend_d = 1'b0;
            end
            state_d = StIdle;
            miso_d  = 1'b0;
        end

        oe_d = (state_d != StIdle) && !cs_n_s;
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            rx_q      <= 16'h0000;
            tx_q      <= 16'h0000;
            is_read_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_pend_q <= 1'b0;
            we_q      <= 1'b0;
            rd_cap_q  <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_pend_q <= we_pend_d;
            we_q      <= we_d;
            rd_cap_q  <= rd_cap_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            err_q     <= err_d;
        end
    end

    assign mm_m.addr     = addr_q;
    assign mm_m.wdata    = wdata_q;
    assign mm_m.we       = we_q;
    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = oe_q;
    assign frame_err_o   = err_q;

endmodule
